// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one 8x8 signed shift-add multiplier between NREQ
// requesters. The block latches the winning requester's operands, pulses
// Mul_Run, follows Mul_Ready through the multiply, then returns the 16-bit
// product with a one-cycle done strobe to that requester.
//
// Build option: define MUL_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// The search starts one past the last granted index. Without it, fixed
// priority applies and the lowest index wins.
//
// Ports:
//   Clk, Reset     clock; synchronous active-low reset
//   req[NREQ]      level requests, held until the matching done
//   a_in, b_in     packed 8-bit operands, requester i at [8i+7:8i]
//   gnt[NREQ]      one-hot grant, LAUNCH through RESPOND
//   done[NREQ]     one-cycle completion pulse to the granted requester
//   Result[16]     product of the last completed operation
//   Busy           high whenever the FSM is not IDLE
//   Mul_A, Mul_B   registered multiplier operands
//   Mul_Run        one-cycle multiplier start pulse
//   Mul_Ready      multiplier ready (low while multiplying)
//   Mul_Out        multiplier product
//   state_dbg      current FSM state encoding
//
// Handshake: a requester raises req[i] and holds it, with stable operands,
// until it is granted. The operands are captured on the IDLE edge that
// selects i. done[i] is the only completion indication. The multiplier side
// is started by a single Mul_Run cycle. Completion is the first Mul_Ready=1
// after Mul_Ready has been seen low.
module mul_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] a_in,
    input  logic [NREQ*8-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [15:0]       Result,
    output logic              Busy,
    output logic [7:0]        Mul_A,
    output logic [7:0]        Mul_B,
    output logic              Mul_Run,
    input  logic              Mul_Ready,
    input  logic [15:0]       Mul_Out,
    output logic [2:0]        state_dbg
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] win_idx;
    logic          win_valid;

`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    logic [IW:0]   cand;

    // Walk the requesters cyclically, starting one past the last grant.
    // One extra bit of width holds ptr+1+i before the wrap back into range.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(1) + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!win_valid && req[cand[IW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rr_ptr <= IW'(NREQ - 1);
        end else if (state == IDLE && win_valid) begin
            rr_ptr <= win_idx;
        end
    end
`else
    // Fixed priority. Scanning downward lets the lowest set index win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (win_valid)  state_nxt = LAUNCH;
            LAUNCH:                    state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!Mul_Ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (Mul_Ready)  state_nxt = RESPOND;
            RESPOND:                   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs decode from the state register and the registered grant index
    // only. This keeps req and Mul_Ready off every output path.
    always_comb begin
        gnt       = '0;
        done      = '0;
        Busy      = (state != IDLE);
        Mul_Run   = (state == LAUNCH);
        state_dbg = state;
        if (state != IDLE) begin
            gnt[gnt_idx] = 1'b1;
        end
        if (state == RESPOND) begin
            done[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            gnt_idx <= '0;
            Mul_A   <= '0;
            Mul_B   <= '0;
            Result  <= '0;
        end else begin
            state <= state_nxt;
            // Operands are captured only at the launch decision, so later
            // changes on a_in/b_in cannot reach the multiplier mid-operation.
            if (state == IDLE && win_valid) begin
                gnt_idx <= win_idx;
                Mul_A   <= a_in[{win_idx, 3'b000} +: 8];
                Mul_B   <= b_in[{win_idx, 3'b000} +: 8];
            end
            if (state == WAIT_DONE && Mul_Ready) begin
                Result <= Mul_Out;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: self-checking bench for mul_arbiter. It contains a
// behavioural multiplier with random latency, requester driver tasks and a
// queue-based scoreboard. A monitor compares every done pulse against the
// expected (lane, operands, product) predicted from the arbitration rules.
// Honours MUL_ARB_ROUND_ROBIN_EN in the same way as the design.
module tb_mul_arbiter;

    localparam int NREQ = 4;
    localparam int EW   = 35;  // {lane[2:0], a[7:0], b[7:0], product[15:0]}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req  = '0;
    logic [NREQ*8-1:0] a_in = '0;
    logic [NREQ*8-1:0] b_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [15:0]       Result;
    logic              Busy;
    logic [7:0]        Mul_A;
    logic [7:0]        Mul_B;
    logic              Mul_Run;
    logic              Mul_Ready = 1'b1;
    logic [15:0]       Mul_Out   = '0;
    logic [2:0]        state_dbg;

    mul_arbiter #(.NREQ(NREQ)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .done      (done),
        .Result    (Result),
        .Busy      (Busy),
        .Mul_A     (Mul_A),
        .Mul_B     (Mul_B),
        .Mul_Run   (Mul_Run),
        .Mul_Ready (Mul_Ready),
        .Mul_Out   (Mul_Out),
        .state_dbg (state_dbg)
    );

    // ---------------- behavioural multiplier ----------------
    logic        mul_rst = 1'b1;
    int          mcnt    = 0;
    logic [15:0] mprod   = '0;

    always @(negedge clk) begin
        if (mul_rst) begin
            Mul_Ready = 1'b1;
            mcnt      = 0;
        end else if (Mul_Run) begin
            mcnt      = $urandom_range(2, 6);
            Mul_Ready = 1'b0;
            mprod     = 16'(int'($signed(Mul_A)) * int'($signed(Mul_B)));
            Mul_Out   = 16'($urandom);
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                Mul_Ready = 1'b1;
                Mul_Out   = mprod;
            end else begin
                Mul_Out = 16'($urandom);
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            tests       = 0;
    int            failed      = 0;
    logic          tmo_flag    = 1'b0;
    logic          end_flag    = 1'b0;
    logic          end_checked = 1'b0;

    // requester-side reference state
    int          svc_left[NREQ];
    logic [7:0]  lane_a[NREQ];
    logic [7:0]  lane_b[NREQ];
    int          rr_last = NREQ - 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- monitor ----------------
    logic          rst_seen  = 1'b0;
    logic          prev_done = 1'b0;
    int            run_cnt   = 0;
    logic [15:0]   last_p    = '0;
    logic [EW-1:0] e;

    always @(posedge clk) rst_seen <= !rst_n;

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_gnt",    32'(gnt),     0);
            check("rst_done",   32'(done),    0);
            check("rst_busy",   32'(Busy),    0);
            check("rst_run",    32'(Mul_Run), 0);
            check("rst_mul_a",  32'(Mul_A),   0);
            check("rst_mul_b",  32'(Mul_B),   0);
            check("rst_result", 32'(Result),  0);
            last_p    = '0;
            prev_done = 1'b0;
            run_cnt   = 0;
        end else begin
            if (prev_done) check("idle_after_done", 32'(Busy), 0);
            if (!Busy) begin
                run_cnt = 0;
                check("idle_gnt",    32'(gnt),     0);
                check("idle_done",   32'(done),    0);
                check("idle_run",    32'(Mul_Run), 0);
                check("held_result", 32'(Result),  32'(last_p));
            end else begin
                if (Mul_Run) run_cnt++;
                if (|done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_lane",  32'(done),   32'(1) << e[34:32]);
                        check("gnt_done",   32'(gnt),    32'(1) << e[34:32]);
                        check("result",     32'(Result), 32'(e[15:0]));
                        check("mul_a",      32'(Mul_A),  32'(e[31:24]));
                        check("mul_b",      32'(Mul_B),  32'(e[23:16]));
                        check("run_pulses", 32'(run_cnt), 1);
                        last_p = e[15:0];
                    end
                end else if (exp_q.size() > 0) begin
                    check("gnt_busy", 32'(gnt), 32'(1) << exp_q[0][34:32]);
                end
            end
            prev_done = |done;
        end
        if (end_flag && !end_checked) begin
            check("queue_empty", 32'(exp_q.size()), 0);
            check("no_timeout",  32'(tmo_flag), 0);
            end_checked = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // Predicts the order in which the pending services complete and queues
    // one expected entry per service. Every pending requester holds req
    // until its services are used up.
    task automatic predict();
        int cnt[NREQ];
        int pick;
        int prod;
        for (int i = 0; i < NREQ; i++) cnt[i] = svc_left[i];
        forever begin
            pick = -1;
`ifdef MUL_ARB_ROUND_ROBIN_EN
            for (int k = 1; k <= NREQ; k++) begin
                if (pick < 0 && cnt[(rr_last + k) % NREQ] > 0) pick = (rr_last + k) % NREQ;
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                if (pick < 0 && cnt[k] > 0) pick = k;
            end
`endif
            if (pick < 0) break;
            prod = int'($signed(lane_a[pick])) * int'($signed(lane_b[pick]));
            exp_q.push_back({3'(pick), lane_a[pick], lane_b[pick], prod[15:0]});
            cnt[pick]--;
            rr_last = pick;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b,
                            input int n);
        svc_left[i] = n;
        lane_a[i]   = a;
        lane_b[i]   = b;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (svc_left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Raises req for all lanes with services left and serves done pulses
    // until every lane is satisfied. drop_lane releases that req early
    // (during WAIT_DONE). perturb overwrites the granted lane's operands
    // one cycle after launch, but only on its final service.
    task automatic run_batch(input int drop_lane, input bit perturb, input int perturb_val);
        int cyc       = 0;
        int since_run = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (svc_left[i] > 0) begin
                req[i]         = 1'b1;
                a_in[8*i +: 8] = lane_a[i];
                b_in[8*i +: 8] = lane_b[i];
            end
        end
        while (pending() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] && svc_left[i] > 0) begin
                    svc_left[i]--;
                    if (svc_left[i] == 0) req[i] = 1'b0;
                end
            end
            if (Mul_Run) since_run = 0;
            else if (since_run >= 0) since_run++;
            if (perturb && since_run == 1) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i] && svc_left[i] == 1) begin
                        a_in[8*i +: 8] = (perturb_val >= 0) ? 8'(perturb_val) : 8'($urandom);
                        if (perturb_val < 0) b_in[8*i +: 8] = 8'($urandom);
                    end
                end
            end
            if (drop_lane >= 0 && since_run == 2 && gnt[drop_lane]) req[drop_lane] = 1'b0;
        end
        if (cyc >= 2000) begin
            $display("FAIL batch_timeout: got %0d cycles required fewer than 2000", cyc);
            tmo_flag = 1'b1;
            req      = '0;
            for (int i = 0; i < NREQ; i++) svc_left[i] = 0;
        end
    endtask

    task automatic reset_mid_op();
        int cyc = 0;
        set_lane(1, 8'($urandom), 8'($urandom), 0);
        req[1]      = 1'b1;
        a_in[15:8]  = lane_a[1];
        b_in[15:8]  = lane_b[1];
        while (!Mul_Run && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) tmo_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rr_last = NREQ - 1;
        cyc     = 0;
        while (!Mul_Ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] set;
        for (int i = 0; i < NREQ; i++) set_lane(i, 8'h00, 8'h00, 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        mul_rst = 1'b0;
        @(negedge clk);

        // single request: 127 * -8
        set_lane(0, 8'h7F, 8'hF8, 1);
        predict();
        run_batch(-1, 1'b0, 0);
        repeat (2) @(negedge clk);

        // corner operands: -128 * -128 on lane 2
        set_lane(2, 8'h80, 8'h80, 1);
        predict();
        run_batch(-1, 1'b0, 0);
        repeat (2) @(negedge clk);

        // three concurrent requesters, lane 0 keeps coming back
`ifdef MUL_ARB_ROUND_ROBIN_EN
        set_lane(0, 8'h11, 8'h05, 2);
`else
        set_lane(0, 8'h11, 8'h05, 3);
`endif
        set_lane(1, 8'hF0, 8'h07, 1);
        set_lane(2, 8'h3C, 8'hC4, 1);
        predict();
        run_batch(-1, 1'b0, 0);
        repeat (2) @(negedge clk);

        // operand change after launch: 5 -> 9 with b = 3
        set_lane(0, 8'd5, 8'd3, 1);
        predict();
        run_batch(-1, 1'b1, 9);
        repeat (2) @(negedge clk);

        // request dropped during WAIT_DONE on lane 1
        set_lane(1, 8'($urandom), 8'($urandom), 1);
        predict();
        run_batch(1, 1'b0, 0);
        repeat (15) @(negedge clk);

        // reset mid-operation, then lane 3 computes 2 * 3
        reset_mid_op();
        set_lane(3, 8'd2, 8'd3, 1);
        predict();
        run_batch(-1, 1'b0, 0);
        repeat (2) @(negedge clk);

        // randomized batches
        for (int t = 0; t < 25; t++) begin
            set = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (set[i]) set_lane(i, 8'($urandom), 8'($urandom), 1);
            end
            predict();
            run_batch(-1, 1'($urandom), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        end_flag = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
